// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN tick scheduler: sequencer states,
// default sizing and a small index-width helper.
package snn_ctrl_pkg;

    localparam int NUM_CORES_DEF = 2;
    localparam int CYC_W_DEF     = 8;
    localparam int TICK_W_DEF    = 16;

    // Sequencer states. IDLE is zero so reset and abort land on the same code.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HOST = 3'd1,
        ST_CALC      = 3'd2,
        ST_LATCH     = 3'd3,
        ST_CLEAR     = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_t;

    // Width of a core index; a single-core build still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mask_next_sel.sv
// Combinational finder: lowest set mask bit strictly above idx, or at/above
// idx when incl is set (incl with idx = 0 gives the lowest set bit overall).
module mask_next_sel
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] mask,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 incl,
    output logic [IDX_W-1:0]     next_idx,
    output logic                 valid
);

    // Scan from the top down so the lowest qualifying bit is the last writer.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves a combinational output unassigned would infer a latch.
        next_idx = '0;
        valid    = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(idx)) || (incl && (i == int'(idx))))) begin
                next_idx = IDX_W'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler for a multi-core SNN array. Per tick it walks the enabled
// cores in ascending order (calc_en for C cycles, then a one-cycle OMEM
// latch strobe), then clears the axon spikes and counts the tick. The host
// gets Wishbone access only while the sequencer is idle.
module tick_scheduler
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int CYC_W     = CYC_W_DEF,
    parameter int TICK_W    = TICK_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_CORES-1:0] core_mask_i,
    input  logic [CYC_W-1:0]     calc_cycles_i,
    input  logic [TICK_W-1:0]    num_ticks_i,
    input  logic                 host_req_i,
    output logic                 host_gnt_o,
    output logic [NUM_CORES-1:0] calc_en_o,
    output logic [NUM_CORES-1:0] spike_latch_o,
    output logic                 imem_clr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [TICK_W-1:0]    tick_count_o
);

    localparam int IDX_W = idx_width(NUM_CORES);

    // Registered state and run configuration captured at start.
    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CYC_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CORES-1:0]  mask_q, mask_d;
    logic [CYC_W-1:0]      cycles_q, cycles_d;
    logic [TICK_W-1:0]     ticks_q, ticks_d;

    // Next values of the output registers.
    logic                  gnt_d;
    logic [NUM_CORES-1:0]  calc_en_d;
    logic [NUM_CORES-1:0]  latch_d;
    logic                  clr_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  err_d;
    logic [TICK_W-1:0]     tick_cnt_d;

    // Core selection results.
    logic [IDX_W-1:0]      start_idx;
    logic                  start_valid;
    logic [IDX_W-1:0]      first_idx;
    logic                  first_valid;
    logic [IDX_W-1:0]      next_idx;
    logic                  next_valid;
    logic [TICK_W-1:0]     n_eff;

    // One-hot enable for core i.
    function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_CORES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Down-counter preload for a CALC phase of c cycles; c = 0 runs one cycle.
    function automatic logic [CYC_W-1:0] calc_load(input logic [CYC_W-1:0] c);
        return (c == '0) ? '0 : c - CYC_W'(1);
    endfunction

    // Lowest enabled core of the mask presented with start.
    mask_next_sel #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_sel_start (
        .mask     (core_mask_i),
        .idx      ('0),
        .incl     (1'b1),
        .next_idx (start_idx),
        .valid    (start_valid)
    );

    // Lowest enabled core of the latched mask, used at each tick start.
    mask_next_sel #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_sel_first (
        .mask     (mask_q),
        .idx      ('0),
        .incl     (1'b1),
        .next_idx (first_idx),
        .valid    (first_valid)
    );

    // Next enabled core above the one just latched.
    mask_next_sel #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_sel_next (
        .mask     (mask_q),
        .idx      (idx_q),
        .incl     (1'b0),
        .next_idx (next_idx),
        .valid    (next_valid)
    );

    // A latched tick count of zero still runs one tick.
    assign n_eff = (ticks_q == '0) ? TICK_W'(1) : ticks_q;

    // Next-state and next-output decode; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        cycles_d   = cycles_q;
        ticks_d    = ticks_q;
        gnt_d      = 1'b0;
        calc_en_d  = '0;
        latch_d    = '0;
        clr_d      = 1'b0;
        busy_d     = busy_o;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tick_cnt_d = tick_count_o;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d  = host_req_i;
                busy_d = 1'b0;
                if (start_i) begin
                    if (!start_valid) begin
                        err_d = 1'b1;
                    end else begin
                        mask_d     = core_mask_i;
                        cycles_d   = calc_cycles_i;
                        ticks_d    = num_ticks_i;
                        tick_cnt_d = '0;
                        busy_d     = 1'b1;
                        if (host_gnt_o) begin
                            // Host still owns the memories: hold its grant until it lets go.
                            state_d = ST_WAIT_HOST;
                            gnt_d   = 1'b1;
                        end else begin
                            state_d   = ST_CALC;
                            idx_d     = start_idx;
                            cnt_d     = calc_load(calc_cycles_i);
                            gnt_d     = 1'b0;
                            calc_en_d = onehot(start_idx);
                        end
                    end
                end
            end

            ST_WAIT_HOST: begin
                if (host_gnt_o) begin
                    // Drop the grant once the request goes away; never re-grant here.
                    gnt_d = host_req_i;
                end else if (first_valid) begin
                    state_d   = ST_CALC;
                    idx_d     = first_idx;
                    cnt_d     = calc_load(cycles_q);
                    calc_en_d = onehot(first_idx);
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_d = ST_LATCH;
                    latch_d = onehot(idx_q);
                end else begin
                    cnt_d     = cnt_q - CYC_W'(1);
                    calc_en_d = onehot(idx_q);
                end
            end

            ST_LATCH: begin
                if (next_valid) begin
                    state_d   = ST_CALC;
                    idx_d     = next_idx;
                    cnt_d     = calc_load(cycles_q);
                    calc_en_d = onehot(next_idx);
                end else begin
                    state_d    = ST_CLEAR;
                    clr_d      = 1'b1;
                    tick_cnt_d = (&tick_count_o) ? tick_count_o : tick_count_o + TICK_W'(1);
                end
            end

            ST_CLEAR: begin
                if ((tick_count_o < n_eff) && first_valid) begin
                    state_d   = ST_CALC;
                    idx_d     = first_idx;
                    cnt_d     = calc_load(cycles_q);
                    calc_en_d = onehot(first_idx);
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            gnt_d     = 1'b0;
            calc_en_d = '0;
            latch_d   = '0;
            clr_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end
    end

    // State, configuration and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: every flop here, outputs included, is cleared by the async
        // reset so the outputs drop the moment rst_n_i falls.
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            cycles_q      <= '0;
            ticks_q       <= '0;
            host_gnt_o    <= 1'b0;
            calc_en_o     <= '0;
            spike_latch_o <= '0;
            imem_clr_o    <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            tick_count_o  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            cycles_q      <= cycles_d;
            ticks_q       <= ticks_d;
            host_gnt_o    <= gnt_d;
            calc_en_o     <= calc_en_d;
            spike_latch_o <= latch_d;
            imem_clr_o    <= clr_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
            tick_count_o  <= tick_cnt_d;
        end
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, giving the number of neuron cores sequenced.
REQ-002 SHALL have parameter CYC_W, default 8, giving the width of the per-core calc cycle count.
REQ-003 SHALL have parameter TICK_W, default 16, giving the width of the tick counters.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: run request, sampled in IDLE only.
REQ-007 SHALL have port abort_i, input, 1 bit: synchronous abort of a run.
REQ-008 SHALL have port core_mask_i, input, NUM_CORES bits: cores to evaluate, sampled at start.
REQ-009 SHALL have port calc_cycles_i, input, CYC_W bits: calc_en duration per core, sampled at start.
REQ-010 SHALL have port num_ticks_i, input, TICK_W bits: ticks per run, sampled at start.
REQ-011 SHALL have port host_req_i, input, 1 bit: the host wants Wishbone access to IMEM/parameters.
REQ-012 SHALL have port host_gnt_o, output, 1 bit: host access granted; the core is frozen.
REQ-013 SHALL have port calc_en_o, output, NUM_CORES bits: per-core neuron evaluate enable.
REQ-014 SHALL have port spike_latch_o, output, NUM_CORES bits: one-cycle OMEM capture strobe.
REQ-015 SHALL have port imem_clr_o, output, 1 bit: one-cycle axon spike clear.
REQ-016 SHALL have ports busy_o, done_o, and err_o, outputs, 1 bit each: status, with done_o and err_o as pulses.
REQ-017 SHALL have port tick_count_o, output, TICK_W bits: ticks completed in the current or last run.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_HOST, CALC, LATCH, CLEAR, and DONE, with a core index register.
REQ-019 SHALL, in IDLE, set host_gnt_o = host_req_i, registered, with one cycle latency.
REQ-020 SHALL, on start_i in IDLE with core_mask_i == 0, pulse err_o for 1 cycle and stay in IDLE.
REQ-021 SHALL, on an accepted start, latch mask/cycles/ticks, clear tick_count_o, and assert busy_o.
REQ-022 SHALL, on an accepted start, go to WAIT_HOST if host_gnt_o = 1 and otherwise go to CALC on the lowest set mask bit.
REQ-023 SHALL hold WAIT_HOST until host_req_i = 0, then drop host_gnt_o and enter CALC the next cycle.
REQ-024 SHALL, in CALC, assert only calc_en_o[idx] for exactly C cycles, where C = latched calc_cycles, and C = 0 is treated as 1.
REQ-025 SHALL, in LATCH, assert spike_latch_o[idx] for 1 cycle, then go to CALC for the next set mask bit or to CLEAR if none.
REQ-026 SHALL, in CLEAR, pulse imem_clr_o, increment tick_count_o (saturating at all-ones), then go to CALC at the lowest set bit if ticks < N, else go to DONE.
REQ-027 SHALL treat N = 0 as N = 1, where N is the latched tick count.
REQ-028 SHALL, in DONE, pulse done_o, deassert busy_o, and return to IDLE.
REQ-029 SHALL NOT grant host_req_i outside IDLE; the host waits for run completion.
REQ-030 SHALL, on abort_i in any non-IDLE state, go to IDLE next cycle, zero all strobes, issue no done_o, and keep tick_count_o.
REQ-031 SHALL give abort_i priority over every other transition.
REQ-032 SHALL ignore start_i when not in IDLE.
REQ-033 SHALL never assert more than one calc_en_o bit at a time, nor assert calc_en_o together with host_gnt_o.
REQ-034 SHALL drive all outputs from registers.

Reset
REQ-035 SHALL, while rst_n_i = 0, immediately force state to IDLE and all outputs to 0, including tick_count_o.
REQ-036 SHALL leave the first post-reset edge in IDLE; a reset mid-run discards the run.

Structure
REQ-037 SHALL place the state enum and NUM_CORES/CYC_W/TICK_W defaults in shared package snn_ctrl_pkg.
REQ-038 SHALL contain one sub-module, mask_next_sel: a combinational lowest-set-bit-above-index finder returning the index and a valid flag.

Verification
REQ-039 SHALL cover: mask = 11, C = 3, N = 1, start at T -> calc_en[0] high T+1..T+3, latch[0] at T+4, calc_en[1] high T+5..T+7, latch[1] at T+8, clr at T+9, done at T+10.
REQ-040 SHALL cover: mask = 10, C = 0, N = 2 -> calc_en[1] 1 cycle per tick, calc_en[0] never high, tick_count_o = 2, one done pulse.
REQ-041 SHALL cover: mask = 00 with start -> err_o pulse, busy_o stays 0.
REQ-042 SHALL cover: host_req_i held high, start at T, host_req_i low at T+5 -> host_gnt_o drops at T+6, calc_en[0] rises at T+7.
REQ-043 SHALL cover: abort_i during CALC of tick 2 of N = 3 -> all strobes 0 next cycle, tick_count_o = 1, no done_o.
REQ-044 SHALL cover: rst_n_i asserted mid-LATCH -> outputs 0 asynchronously, FSM in IDLE after release.
